// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - shares one single-port framebuffer RAM between VGA scanout and a host port
// Optional feature macro: VGA_FB_VBLANK_ONLY_EN (host writes accepted only during vertical blanking)

module vga_fb_arbiter #(
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 515,
  parameter int H_TOTAL     = 800,
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int AW          = 15,
  parameter int DW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    px,
  input  logic [9:0]    py,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pix_idx,
  output logic          pix_de,
  output logic          vblank
);

  localparam int V_TOTAL = 525;

  localparam logic [9:0]    HS       = 10'(H_ACT_START);
  localparam logic [9:0]    HE       = 10'(H_ACT_END);
  localparam logic [9:0]    VS       = 10'(V_ACT_START);
  localparam logic [9:0]    VE       = 10'(V_ACT_END);
  localparam logic [9:0]    HL       = 10'(H_TOTAL - 1);
  localparam logic [9:0]    VL       = 10'(V_TOTAL - 1);
  localparam logic [10:0]   AX_OFF   = 11'(H_ACT_START - 2);
  localparam logic [10:0]   ACT_W    = 11'(H_ACT_END - H_ACT_START);
  localparam logic [AW-1:0] FB_W_A   = AW'(FB_W);
  localparam logic [AW-1:0] FB_SIZE  = AW'(FB_W * FB_H);

  logic [AW-1:0] row_base_q, row_base_d;
  logic [DW-1:0] pix_idx_q, pix_idx_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic          vblank_q, vblank_d;
  logic          disp_cap_q, disp_cap_d;
  logic          host_cap_q, host_cap_d;
  logic          host_oor_q, host_oor_d;
  logic          host_rvalid_q, host_rvalid_d;

  logic [10:0]   ax;
  logic [9:0]    px_n, py_n;
  logic [1:0]    row_phase;
  logic          h_act, v_act, v_act_n, de_n;
  logic          slot, in_range, host_acc;
  logic [AW-1:0] disp_addr;

  always_comb begin
    h_act   = (px >= HS) && (px < HE);
    v_act   = (py >= VS) && (py < VE);
    pix_de  = h_act && v_act;

    // Position the sync generator will present after this edge, so registered
    // outputs line up with the pixel they belong to.
    px_n = (px == HL) ? 10'd0 : px + 10'd1;
    py_n = py;
    if (px == HL) begin
      py_n = (py == VL) ? 10'd0 : py + 10'd1;
    end
    v_act_n = (py_n >= VS) && (py_n < VE);
    de_n    = (px_n >= HS) && (px_n < HE) && v_act_n;

    // Fetch two pixels ahead: one cycle RAM latency plus one cycle to register.
    ax        = {1'b0, px} - AX_OFF;
    slot      = !rst && v_act && (ax < ACT_W) && (ax[1:0] == 2'b00);
    disp_addr = row_base_q + {{(AW-9){1'b0}}, ax[10:2]};
    row_phase = py[1:0] - VS[1:0];

    in_range = host_addr < FB_SIZE;
`ifdef VGA_FB_VBLANK_ONLY_EN
    host_ready = !rst && !slot && (!host_we || vblank_q);
`else
    host_ready = !rst && !slot;
`endif
    host_acc  = host_valid && host_ready;

    mem_en    = slot || (host_acc && in_range);
    mem_we    = !slot && host_acc && host_we && in_range;
    mem_addr  = slot ? disp_addr : host_addr;
    mem_wdata = host_wdata;

    row_base_d = row_base_q;
    if (px == HL) begin
      if (py == VS - 10'd1) begin
        row_base_d = '0;
      end else if (v_act && (row_phase == 2'd3)) begin
        row_base_d = row_base_q + FB_W_A;
      end
    end

    pix_idx_d = pix_idx_q;
    if (!de_n) begin
      pix_idx_d = '0;
    end else if (disp_cap_q) begin
      pix_idx_d = mem_rdata;
    end

    vblank_d      = !v_act_n;
    disp_cap_d    = slot;
    host_cap_d    = host_acc && !host_we;
    host_oor_d    = host_acc && !host_we && !in_range;
    host_rvalid_d = host_cap_q;
    host_rdata_d  = host_rdata_q;
    if (host_cap_q) begin
      host_rdata_d = host_oor_q ? '0 : mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_base_q    <= '0;
      pix_idx_q     <= '0;
      host_rdata_q  <= '0;
      vblank_q      <= 1'b1;
      disp_cap_q    <= 1'b0;
      host_cap_q    <= 1'b0;
      host_oor_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      row_base_q    <= row_base_d;
      pix_idx_q     <= pix_idx_d;
      host_rdata_q  <= host_rdata_d;
      vblank_q      <= vblank_d;
      disp_cap_q    <= disp_cap_d;
      host_cap_q    <= host_cap_d;
      host_oor_q    <= host_oor_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign pix_idx     = pix_idx_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign vblank      = vblank_q;

endmodule
